// File: rtl/jtopl_wrsched_if.sv
// Host/mmr bus bundle for the OPL write scheduler.
//   master : host side, drives host_we/host_addr/host_din and observes status
//   slave  : scheduler side, accepts host writes and drives the mmr strobe
//            (opl_din/opl_addr/opl_write) plus status (busy/full/level/ovf)
interface jtopl_wrsched_if #(
  parameter int AW = 3
);
  logic          host_we;
  logic          host_addr;
  logic [7:0]    host_din;
  logic [7:0]    opl_din;
  logic          opl_addr;
  logic          opl_write;
  logic          busy;
  logic          full;
  logic [AW:0]   level;
  logic          ovf;

  modport master (
    output host_we, host_addr, host_din,
    input  opl_din, opl_addr, opl_write, busy, full, level, ovf
  );

  modport slave (
    input  host_we, host_addr, host_din,
    output opl_din, opl_addr, opl_write, busy, full, level, ovf
  );
endinterface

// File: rtl/jtopl_wrsched.sv
// Host-side write scheduler in front of the OPL register file.
// Host writes ({a0, data}) are queued in a 2**AW entry FIFO and replayed to
// mmr one at a time as single-clk strobes. After each strobe the scheduler
// waits ADDR_WAIT (address port) or DATA_WAIT (data port) cen ticks before
// the next entry may be popped.
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   cen  : master clock enable, paces the recovery countdown only
//   bus  : jtopl_wrsched_if.slave
//          host_we/host_addr/host_din in; opl_din/opl_addr/opl_write out;
//          busy, full, level (0..2**AW) and sticky ovf status out
module jtopl_wrsched #(
  parameter int AW        = 3,
  parameter int ADDR_WAIT = 12,
  parameter int DATA_WAIT = 84
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cen,
  jtopl_wrsched_if.slave bus
);

  localparam int DEPTH = 1 << AW;
  localparam int MAXW  = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int CW    = $clog2(MAXW + 1);

  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ADDR = CW'(ADDR_WAIT);
  localparam logic [CW-1:0] CNT_DATA = CW'(DATA_WAIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_q;
  logic [AW:0]   level_nxt;
  logic          full_q;
  logic          busy_q;
  logic          ovf_q;
  logic          opl_write_q;
  logic          opl_addr_q;
  logic [7:0]    opl_din_q;
  logic          pop;
  logic          push;
  logic          drop;
  logic          fsm_active_nxt;

  // Pop is the IDLE dequeue; a push into a full FIFO is still accepted when a
  // pop frees a slot on the same edge. fsm_active_nxt tells whether the FSM
  // will be outside IDLE after this edge, so busy can be registered as the
  // post-edge view.
  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    pop            = (state == S_IDLE) && (level_q != '0);
    push           = bus.host_we && (!full_q || pop);
    drop           = bus.host_we && full_q && !pop;
    level_nxt      = level_q;
    fsm_active_nxt = 1'b0;
    if (push && !pop)
      level_nxt = level_q + LVL_ONE;
    else if (pop && !push)
      level_nxt = level_q - LVL_ONE;
    case (state)
      S_IDLE:  fsm_active_nxt = pop;
      S_ISSUE: fsm_active_nxt = 1'b1;
      S_WAIT:  fsm_active_nxt = !(cen && (cnt == CNT_ONE));
      default: fsm_active_nxt = 1'b0;
    endcase
  end

  // NOTE: the storage array has no reset; pointers and level are reset, so
  // stale contents are never read and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {bus.host_addr, bus.host_din};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read
  // below sees the pre-edge value (e.g. opl_addr in ISSUE is the popped entry).
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      full_q      <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
      opl_write_q <= 1'b0;
      opl_addr_q  <= 1'b0;
      opl_din_q   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (drop) ovf_q  <= 1'b1;
      level_q     <= level_nxt;
      full_q      <= (level_nxt == LVL_FULL);
      busy_q      <= (level_nxt != '0) || fsm_active_nxt;
      opl_write_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (pop) begin
            {opl_addr_q, opl_din_q} <= mem[rd_ptr];
            opl_write_q             <= 1'b1;
            state                   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= opl_addr_q ? CNT_DATA : CNT_ADDR;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // The tick that brings cnt to zero also releases the FSM.
          if (cen) begin
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE)
              state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.opl_write = opl_write_q;
  assign bus.opl_addr  = opl_addr_q;
  assign bus.opl_din   = opl_din_q;
  assign bus.busy      = busy_q;
  assign bus.full      = full_q;
  assign bus.level     = level_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_jtopl_wrsched.sv
// Self-checking bench for jtopl_wrsched.
// A timestamp-based model (queue of accepted writes, edge at which the
// scheduler becomes free, cen ticks still owed) predicts every output on
// every clk; directed tests add hand-computed literal expectations.
module tb_jtopl_wrsched;

  localparam int AW        = 3;
  localparam int ADDR_WAIT = 12;
  localparam int DATA_WAIT = 84;
  localparam int DEPTH     = 1 << AW;
  localparam int HIST      = 131072;
  localparam int NEVER     = 32'h7fff_ffff;

  localparam int CEN_ZERO   = 0;
  localparam int CEN_ONE    = 1;
  localparam int CEN_EVERY4 = 2;
  localparam int CEN_RAND   = 3;
  localparam int CEN_MANUAL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cen = 1'b0;

  jtopl_wrsched_if #(.AW(AW)) bus ();

  jtopl_wrsched #(
    .AW(AW), .ADDR_WAIT(ADDR_WAIT), .DATA_WAIT(DATA_WAIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cen(cen),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // model state
  logic [8:0] m_q[$];
  int         m_e         = 0;
  int         m_idle_edge = 0;
  int         m_ticks     = 0;
  int         m_tick_from = 0;
  bit         m_valid     = 1'b0;
  bit         exp_write   = 1'b0;
  bit         exp_ovf     = 1'b0;
  logic [8:0] exp_out     = '0;
  int         m_drops     = 0;
  bit         cen_hist [HIST];
  int         strobe_edges[$];
  logic [8:0] strobe_data[$];

  int cen_mode = CEN_ZERO;
  int cen_div  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, m_e);
    end
  endtask

  function automatic int ticks_between(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++)
      if (i >= 0 && i < HIST && cen_hist[i]) n++;
    return n;
  endfunction

  function automatic bit hist_at(input int i);
    return (i >= 0 && i < HIST) ? cen_hist[i] : 1'b0;
  endfunction

  // cen pattern generator
  always @(negedge clk) begin
    case (cen_mode)
      CEN_ZERO:   cen = 1'b0;
      CEN_ONE:    cen = 1'b1;
      CEN_EVERY4: begin
        cen     = (cen_div == 0);
        cen_div = (cen_div + 1) % 4;
      end
      CEN_RAND:   cen = 1'($urandom_range(0, 1));
      default:    ;
    endcase
  end

  // Model step on each edge, then compare once outputs have settled.
  always @(posedge clk) begin : model
    bit         pop;
    logic [8:0] head;
    m_e++;
    if (m_e < HIST) cen_hist[m_e] = cen;
    if (rst) begin
      m_q.delete();
      m_idle_edge = m_e;
      m_ticks     = 0;
      exp_write   = 1'b0;
      exp_ovf     = 1'b0;
      exp_out     = '0;
      m_drops     = 0;
      m_valid     = 1'b1;
    end else if (m_valid) begin
      if (m_ticks > 0 && m_e >= m_tick_from && cen) begin
        m_ticks--;
        if (m_ticks == 0) m_idle_edge = m_e;
      end
      pop       = (m_e - 1 >= m_idle_edge) && (m_q.size() > 0);
      exp_write = pop;
      if (pop) begin
        head        = m_q.pop_front();
        exp_out     = head;
        m_ticks     = head[8] ? DATA_WAIT : ADDR_WAIT;
        m_tick_from = m_e + 2;
        m_idle_edge = NEVER;
      end
      if (bus.host_we) begin
        if (m_q.size() < DEPTH) m_q.push_back({bus.host_addr, bus.host_din});
        else begin
          m_drops++;
          exp_ovf = 1'b1;
        end
      end
    end
    #1;
    if (m_valid) begin
      check("cyc_level", 32'(bus.level), 32'(m_q.size()));
      check("cyc_full", 32'(bus.full), 32'(m_q.size() == DEPTH));
      check("cyc_busy", 32'(bus.busy), 32'((m_q.size() != 0) || (m_e < m_idle_edge)));
      check("cyc_ovf", 32'(bus.ovf), 32'(exp_ovf));
      check("cyc_write", 32'(bus.opl_write), 32'(exp_write));
      check("cyc_out", 32'({bus.opl_addr, bus.opl_din}), 32'(exp_out));
      if (bus.opl_write === 1'b1) begin
        strobe_edges.push_back(m_e);
        strobe_data.push_back({bus.opl_addr, bus.opl_din});
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    bus.host_we   = 1'b1;
    bus.host_addr = a;
    bus.host_din  = d;
    tick();
    bus.host_we   = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (bus.busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_strobes(input int target, input int budget, input string name);
    int n = 0;
    while (strobe_edges.size() < target && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(strobe_edges.size()), 32'(target));
  endtask

  initial begin
    int b;
    int d0;
    int s1;
    int s2;
    logic [7:0] d;
    logic       a;

    bus.host_we   = 1'b0;
    bus.host_addr = 1'b0;
    bus.host_din  = '0;
    tick(3);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    check("rst_write", 32'(bus.opl_write), 32'd0);
    check("rst_din", 32'(bus.opl_din), 32'd0);
    rst = 1'b0;
    tick();

    // Address/data pair with cen every 4 clks.
    cen_mode = CEN_EVERY4;
    tick();
    b  = strobe_edges.size();
    d0 = m_e;
    wr(1'b0, 8'h20);
    wr(1'b1, 8'h01);
    wait_strobes(b + 2, 400, "t2_strobes");
    wait_idle(1000, "t2_idle");
    if (strobe_edges.size() >= b + 2) begin
      s1 = strobe_edges[b];
      s2 = strobe_edges[b+1];
      check("t2_latency", 32'(s1 - d0), 32'd2);
      check("t2_first", 32'(strobe_data[b]), 32'h020);
      check("t2_second", 32'(strobe_data[b+1]), 32'h101);
      check("t2_addr_ticks", 32'(ticks_between(s1 + 2, s2 - 1)), 32'd12);
      check("t2_addr_lasttick", 32'(hist_at(s2 - 1)), 32'd1);
      check("t2_data_ticks", 32'(ticks_between(s2 + 2, m_e)), 32'd84);
      check("t2_data_lasttick", 32'(hist_at(m_e)), 32'd1);
    end
    check("t2_hold_din", 32'(bus.opl_din), 32'h01);
    check("t2_hold_addr", 32'(bus.opl_addr), 32'd1);

    // Fill with cen held low: one entry goes to ISSUE, eight fill the FIFO,
    // the tenth write is dropped.
    cen_mode = CEN_ZERO;
    tick();
    b = strobe_edges.size();
    for (int i = 0; i < 10; i++) begin
      d = 8'(i * 17);
      a = i[0];
      wr(a, d);
    end
    check("t3_level", 32'(bus.level), 32'd8);
    check("t3_full", 32'(bus.full), 32'd1);
    check("t3_ovf", 32'(bus.ovf), 32'd1);
    cen_mode = CEN_ONE;
    wait_strobes(b + 9, 3000, "t3_strobes");
    wait_idle(1000, "t3_idle");
    for (int i = 0; i < 9; i++) begin
      d = 8'(i * 17);
      a = i[0];
      if (strobe_data.size() > b + i)
        check("t3_order", 32'(strobe_data[b+i]), 32'({a, d}));
    end
    check("t3_ovf_sticky", 32'(bus.ovf), 32'd1);

    // Reset while waiting with four entries queued.
    cen_mode = CEN_ZERO;
    tick();
    for (int i = 0; i < 5; i++) wr(1'b1, 8'(8'hA0 + i));
    tick(2);
    check("t1_level_before", 32'(bus.level), 32'd4);
    check("t1_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_write_in_rst", 32'(bus.opl_write), 32'd0);
    end
    check("t1_level", 32'(bus.level), 32'd0);
    check("t1_busy", 32'(bus.busy), 32'd0);
    check("t1_ovf", 32'(bus.ovf), 32'd0);
    rst = 1'b0;
    tick();
    check("t1_write_after_rst", 32'(bus.opl_write), 32'd0);

    // Push and pop on the same clk while full.
    cen_mode = CEN_MANUAL;
    cen      = 1'b0;
    tick();
    for (int i = 0; i < 9; i++) wr(1'b0, 8'(8'h50 + i));
    check("t4_full", 32'(bus.full), 32'd1);
    check("t4_level_full", 32'(bus.level), 32'd8);
    cen = 1'b1;
    tick(12);
    wr(1'b1, 8'h77);
    check("t4_level", 32'(bus.level), 32'd8);
    check("t4_ovf", 32'(bus.ovf), 32'd0);
    check("t4_pop_strobe", 32'(bus.opl_write), 32'd1);
    check("t4_pop_data", 32'({bus.opl_addr, bus.opl_din}), 32'h051);
    cen_mode = CEN_ONE;
    wait_idle(3000, "t4_idle");

    // cen held high: alternating address/data writes.
    tick();
    b  = strobe_edges.size();
    d0 = m_e;
    for (int i = 0; i < 10; i++) begin
      a = i[0];
      wr(a, 8'(8'h40 + i));
      tick();
    end
    wait_strobes(b + 10, 2000, "t5_strobes");
    wait_idle(500, "t5_idle");
    if (strobe_edges.size() >= b + 10) begin
      check("t5_latency", 32'(strobe_edges[b] - d0), 32'd2);
      for (int i = 0; i < 9; i++) begin
        a = i[0];
        check(a ? "t5_gap_data" : "t5_gap_addr",
              32'(strobe_edges[b+i+1] - strobe_edges[b+i]), a ? 32'd86 : 32'd14);
      end
    end

    // Random host traffic with random cen.
    cen_mode = CEN_RAND;
    for (int i = 0; i < 40000; i++) begin
      bus.host_we   = ($urandom_range(0, 15) == 0);
      bus.host_addr = 1'($urandom_range(0, 1));
      bus.host_din  = 8'($urandom_range(0, 255));
      tick();
    end
    bus.host_we = 1'b0;
    cen_mode    = CEN_ONE;
    wait_idle(3000, "t6_idle");
    check("t6_level", 32'(bus.level), 32'd0);
    check("t6_ovf_iff_drop", 32'(bus.ovf), 32'(m_drops > 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
